// File: rtl/protect_access_monitor_pkg.sv
// Shared types and helpers for the bus write-protection monitor.
// The state encodings are also used by consumers of the protection flag.
package protect_access_monitor_pkg;

  typedef enum logic {
    ST_CONFIG = 1'b0,
    ST_ARMED  = 1'b1
  } state_e;

  // Width of a window index; at least one bit even for a single window.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/protect_region_cmp.sv
// One protected address window: base/limit/enable registers and an
// inclusive unsigned range compare against the current bus address.
module protect_region_cmp #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 wr_en_i,
  input  logic [BUS_WIDTH-1:0] base_i,
  input  logic [BUS_WIDTH-1:0] limit_i,
  input  logic                 en_i,
  input  logic [BUS_WIDTH-1:0] addr_i,
  output logic                 hit_o
);

  logic [BUS_WIDTH-1:0] base_q;
  logic [BUS_WIDTH-1:0] limit_q;
  logic                 en_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      base_q  <= '0;
      limit_q <= '0;
      en_q    <= 1'b0;
    end else if (wr_en_i) begin
      base_q  <= base_i;
      limit_q <= limit_i;
      en_q    <= en_i;
    end
  end

  // An inverted window (base above limit) can never satisfy both bounds.
  assign hit_o = en_q && (base_q <= addr_i) && (addr_i <= limit_q);

endmodule

// File: rtl/protect_access_monitor.sv
// Watches accepted bus writes against programmable protected windows and
// reports violations with the offending address and a saturating count.
module protect_access_monitor
  import protect_access_monitor_pkg::*;
#(
  parameter  int BUS_WIDTH  = 32,
  parameter  int REGION_NUM = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int IDX_W      = idx_width(REGION_NUM)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [BUS_WIDTH-1:0] cfg_base,
  input  logic [BUS_WIDTH-1:0] cfg_limit,
  input  logic                 cfg_en,
  input  logic                 lock,
  input  logic                 bus_valid,
  input  logic                 bus_ready,
  input  logic                 bus_write,
  input  logic [BUS_WIDTH-1:0] bus_addr,
  output logic                 armed,
  output logic                 violation,
  output logic [BUS_WIDTH-1:0] violation_addr,
  output logic [CNT_WIDTH-1:0] violation_count,
  output logic                 cfg_err
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_e state_q, state_d;

  logic                 idx_ok;
  logic                 cfg_wr_ok;
  logic [REGION_NUM-1:0] hit_vec;
  logic                 hit_any;
  logic                 accept;
  logic                 viol;
  logic                 cfg_err_d;

  logic                 violation_q;
  logic [BUS_WIDTH-1:0] violation_addr_q;
  logic [CNT_WIDTH-1:0] violation_count_q;
  logic                 cfg_err_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_CONFIG;
    else         state_q <= state_d;
  end

  // ARMED is only left through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CONFIG && lock) state_d = ST_ARMED;
  end

  assign idx_ok    = (32'(cfg_idx) < 32'(REGION_NUM));
  assign cfg_wr_ok = cfg_we && (state_q == ST_CONFIG) && idx_ok;
  assign cfg_err_d = cfg_we && ((state_q == ST_ARMED) || !idx_ok);

  for (genvar i = 0; i < REGION_NUM; i++) begin : g_region
    protect_region_cmp #(
      .BUS_WIDTH(BUS_WIDTH)
    ) u_cmp (
      .clk     (clk),
      .nreset  (nreset),
      .wr_en_i (cfg_wr_ok && (cfg_idx == IDX_W'(i))),
      .base_i  (cfg_base),
      .limit_i (cfg_limit),
      .en_i    (cfg_en),
      .addr_i  (bus_addr),
      .hit_o   (hit_vec[i])
    );
  end

  // Overlapping windows collapse into one hit.
  assign hit_any = |hit_vec;
  assign accept  = bus_valid && bus_ready && bus_write;
  assign viol    = accept && hit_any && (state_q == ST_ARMED);

  // Output register stage: one cycle after the offending write.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      violation_q       <= 1'b0;
      violation_addr_q  <= '0;
      violation_count_q <= '0;
      cfg_err_q         <= 1'b0;
    end else begin
      violation_q <= viol;
      cfg_err_q   <= cfg_err_d;
      if (viol) begin
        violation_addr_q  <= bus_addr;
        violation_count_q <= sat_inc(violation_count_q);
      end
    end
  end

  assign armed           = (state_q == ST_ARMED);
  assign violation       = violation_q;
  assign violation_addr  = violation_addr_q;
  assign violation_count = violation_count_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_protect_access_monitor.sv
// Scoreboard bench for protect_access_monitor: three windows (one index out
// of range), 2-bit counter so saturation is reachable quickly.
module tb_protect_access_monitor;

  localparam int BW = 32;
  localparam int RN = 3;
  localparam int CW = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [BW-1:0] cfg_base = '0;
  logic [BW-1:0] cfg_limit = '0;
  logic          cfg_en = 1'b0;
  logic          lock = 1'b0;
  logic          bus_valid = 1'b0;
  logic          bus_ready = 1'b0;
  logic          bus_write = 1'b0;
  logic [BW-1:0] bus_addr = '0;
  logic          armed;
  logic          violation;
  logic [BW-1:0] violation_addr;
  logic [CW-1:0] violation_count;
  logic          cfg_err;

  protect_access_monitor #(
    .BUS_WIDTH (BW),
    .REGION_NUM(RN),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_base       (cfg_base),
    .cfg_limit      (cfg_limit),
    .cfg_en         (cfg_en),
    .lock           (lock),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_write      (bus_write),
    .bus_addr       (bus_addr),
    .armed          (armed),
    .violation      (violation),
    .violation_addr (violation_addr),
    .violation_count(violation_count),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          armed;
    logic          viol;
    logic [BW-1:0] vaddr;
    logic [CW-1:0] cnt;
    logic          cerr;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [BW-1:0] m_base [RN];
  logic [BW-1:0] m_lim  [RN];
  logic          m_en   [RN];
  logic          m_armed;
  logic [BW-1:0] m_vaddr;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < RN; i++) begin
      m_base[i] = '0;
      m_lim[i]  = '0;
      m_en[i]   = 1'b0;
    end
    m_armed = 1'b0;
    m_vaddr = '0;
    m_cnt   = '0;
    q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".armed"}, 64'(armed), 64'(0));
    check({tag, ".viol"},  64'(violation), 64'(0));
    check({tag, ".vaddr"}, 64'(violation_addr), 64'(0));
    check({tag, ".cnt"},   64'(violation_count), 64'(0));
    check({tag, ".cerr"},  64'(cfg_err), 64'(0));
  endtask

  // Drive one cycle of stimulus, predict the outputs after the edge, then compare.
  task automatic step(input string tag, input logic we, input logic [IW-1:0] idx,
                      input logic [BW-1:0] b, input logic [BW-1:0] l, input logic e,
                      input logic lk, input logic v, input logic r, input logic w,
                      input logic [BW-1:0] a);
    exp_t x;
    logic hit;
    logic vl;
    exp_t o;
    cfg_we = we; cfg_idx = idx; cfg_base = b; cfg_limit = l; cfg_en = e;
    lock = lk; bus_valid = v; bus_ready = r; bus_write = w; bus_addr = a;
    hit = 1'b0;
    for (int i = 0; i < RN; i++)
      if (m_en[i] && m_base[i] <= a && a <= m_lim[i]) hit = 1'b1;
    vl = v && r && w && hit && m_armed;
    x.cerr = we && (m_armed || int'(idx) >= RN);
    if (we && !m_armed && int'(idx) < RN) begin
      m_base[idx] = b; m_lim[idx] = l; m_en[idx] = e;
    end
    if (vl) begin
      m_vaddr = a;
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    if (lk) m_armed = 1'b1;
    x.tag = tag; x.armed = m_armed; x.viol = vl; x.vaddr = m_vaddr; x.cnt = m_cnt;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check({tag, ".sb_empty"}, 64'(1), 64'(0));
    end else begin
      o = q.pop_front();
      check({o.tag, ".armed"}, 64'(armed), 64'(o.armed));
      check({o.tag, ".viol"},  64'(violation), 64'(o.viol));
      check({o.tag, ".vaddr"}, 64'(violation_addr), 64'(o.vaddr));
      check({o.tag, ".cnt"},   64'(violation_count), 64'(o.cnt));
      check({o.tag, ".cerr"},  64'(cfg_err), 64'(o.cerr));
    end
  endtask

  task automatic cfg(input string t, input logic [IW-1:0] i, input logic [BW-1:0] b,
                     input logic [BW-1:0] l, input logic e);
    step(t, 1'b1, i, b, l, e, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic do_lock(input string t);
    step(t, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic wr(input string t, input logic [BW-1:0] a);
    step(t, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
  endtask
  task automatic rd(input string t, input logic [BW-1:0] a);
    step(t, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a);
  endtask
  task automatic idle(input string t);
    step(t, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input string t);
    cfg_we = 0; lock = 0; bus_valid = 0; bus_ready = 0; bus_write = 0;
    nreset = 1'b0;
    #1;
    check_zero(t);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    do_reset("t0_rst");

    // 1: basic violation
    cfg("t1_cfg", 2'd0, 32'h1000, 32'h1FFF, 1'b1);
    do_lock("t1_lock");
    wr("t1_wr", 32'h1800);
    check("t1_count", 64'(violation_count), 64'(1));
    idle("t1_idle");

    // 2: outside window, read inside, unaccepted write inside
    wr("t2_lo", 32'h0FFF);
    wr("t2_hi", 32'h2000);
    rd("t2_rd", 32'h1800);
    step("t2_nrdy", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1800);

    // 3: inclusive boundaries back-to-back
    do_reset("t3_rst");
    cfg("t3_cfg", 2'd0, 32'h1000, 32'h1FFF, 1'b1);
    do_lock("t3_lock");
    wr("t3_b0", 32'h1000);
    check("t3_addr0", 64'(violation_addr), 64'h1000);
    wr("t3_b1", 32'h1FFF);
    check("t3_addr1", 64'(violation_addr), 64'h1FFF);
    idle("t3_idle");
    check("t3_count", 64'(violation_count), 64'(2));

    // 4: no check before lock, write+lock same cycle, locked config, bad index
    do_reset("t4_rst");
    cfg("t4_cfg", 2'd0, 32'h1000, 32'h1FFF, 1'b1);
    cfg("t4_badidx", 2'd3, 32'h0, 32'hFFFF_FFFF, 1'b1);
    wr("t4_prelock", 32'h1800);
    step("t4_lockwr", 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1800);
    step("t4_cfglate", 1'b1, 2'd0, 32'h0, 32'h0FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("t4_cerr", 64'(cfg_err), 64'(1));
    idle("t4_errdrop");
    wr("t4_old", 32'h1800);
    wr("t4_new", 32'h0500);

    // overlap counts once, inverted window never hits, lock with cfg same cycle
    do_reset("t7_rst");
    cfg("t7_w0", 2'd0, 32'h1000, 32'h1FFF, 1'b1);
    cfg("t7_w2", 2'd2, 32'h5000, 32'h4000, 1'b1);
    step("t7_w1lk", 1'b1, 2'd1, 32'h1800, 32'h2FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    wr("t7_ovl", 32'h1900);
    check("t7_ovlcnt", 64'(violation_count), 64'(1));
    wr("t7_w1only", 32'h2800);
    wr("t7_inv", 32'h4800);

    // 5: saturation of the 2-bit counter
    do_reset("t5_rst");
    cfg("t5_cfg", 2'd0, 32'h1000, 32'h1FFF, 1'b1);
    do_lock("t5_lock");
    for (int k = 0; k < 5; k++) wr($sformatf("t5_v%0d", k), 32'h1000 + 32'(k));
    check("t5_sat", 64'(violation_count), 64'(3));
    idle("t5_idle");

    // 6: asynchronous reset during a violating burst
    wr("t6_burst", 32'h1234);
    nreset = 1'b0;
    #1;
    check_zero("t6_async");
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    wr("t6_cfgmode", 32'h1800);
    do_lock("t6_lock");
    wr("t6_nowin", 32'h1800);
    do_reset("t6_rst2");
    cfg("t6_cfg", 2'd0, 32'h1000, 32'h1FFF, 1'b1);
    do_lock("t6_lock2");
    wr("t6_flag", 32'h1800);
    check("t6_flagaddr", 64'(violation_addr), 64'h1800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
